// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: state type and helpers shared by the SRAM controller files.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sram_ctrl_pkg;
`include "sram_ctrl_defs.vh"

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_PRE     = PRE,
    S_ACCESS  = ACCESS,
    S_RECOVER = RECOVER
  } state_t;

  // Used to size the phase counter for the longer of the two timed phases.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sram_ctrl_defs.vh
// sram_ctrl_defs.vh
// Shared FSM state encoding for the SRAM sequencing controller.
// Pulled into sram_ctrl_pkg so every file sees one definition.
`ifndef SRAM_CTRL_DEFS_VH
`define SRAM_CTRL_DEFS_VH
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRE     = 2'd1;
  localparam logic [1:0] ACCESS  = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;
`endif

// File: rtl/sram_row_decoder.sv
// sram_row_decoder: ADDR_W -> 2**ADDR_W one-hot wordline decoder with enable.
// Latency: combinational, zero cycles.
// Backpressure: none; output is all-zero whenever en = 0.
// Ports: en (decode enable), addr (row address), onehot (wordline selects).
module sram_row_decoder #(
  parameter int ADDR_W = 4
) (
  input  logic                   en,
  input  logic [ADDR_W-1:0]      addr,
  output logic [(2**ADDR_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences precharge -> wordline (write drive / sense) -> recovery per access.
// Latency: rsp_valid PRE_CYC+WL_CYC+1 cycles after the handshake; 1 access per PRE_CYC+WL_CYC+2 cycles.
// Backpressure: req_ready high only in IDLE; requests seen while busy are ignored.
// Ports: clk/reset; req_* request handshake; rsp_valid/rsp_rdata completion;
//        wl/precharge/bl_drive_en/bl/blb/sense_en drive the array; sense_in returns sensed data.
// PRE_CYC and WL_CYC must both be at least 1.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [(2**ADDR_W)-1:0] wl,
  output logic                   precharge,
  output logic                   bl_drive_en,
  output logic [DATA_W-1:0]      bl,
  output logic [DATA_W-1:0]      blb,
  output logic                   sense_en,
  input  logic [DATA_W-1:0]      sense_in
);

  localparam int CNT_W = $clog2(max_int(PRE_CYC, WL_CYC)) + 1;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  // Wordlines come straight from registered state and the latched address,
  // so they can only be active in ACCESS, when precharge is already low.
  sram_row_decoder #(
    .ADDR_W (ADDR_W)
  ) u_row_decoder (
    .en     (state == S_ACCESS),
    .addr   (addr_q),
    .onehot (wl)
  );

  // All array controls are registered and set on the edge that enters the
  // cycle they belong to, so they change together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      precharge   <= 1'b0;
      bl_drive_en <= 1'b0;
      bl          <= '0;
      blb         <= '0;
      sense_en    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      sense_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= CNT_W'(PRE_CYC - 1);
            state     <= S_PRE;
            req_ready <= 1'b0;
            precharge <= 1'b1;
          end
        end
        S_PRE: begin
          if (cnt == '0) begin
            state       <= S_ACCESS;
            cnt         <= CNT_W'(WL_CYC - 1);
            precharge   <= 1'b0;
            bl_drive_en <= we_q;
            bl          <= we_q ? wdata_q : '0;
            blb         <= we_q ? ~wdata_q : '0;
            // With a single-cycle wordline phase the first ACCESS cycle is also the last.
            sense_en    <= !we_q && (WL_CYC == 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) rsp_rdata <= sense_in;
            state       <= S_RECOVER;
            bl_drive_en <= 1'b0;
            bl          <= '0;
            blb         <= '0;
            rsp_valid   <= 1'b1;
          end else begin
            cnt      <= cnt - 1'b1;
            // Next cycle has counter 0: that is the sensing cycle for reads.
            sense_en <= !we_q && (cnt == CNT_W'(1));
          end
        end
        S_RECOVER: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        reset, req_valid, req_ready, req_we, rsp_valid;
  logic [3:0]  req_addr;
  logic [7:0]  req_wdata, rsp_rdata, bl, blb, sense_in;
  logic [15:0] wl;
  logic        precharge, bl_drive_en, sense_en;

  // PRE_CYC=3, WL_CYC=1 instance
  logic        b_reset, b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [3:0]  b_req_addr;
  logic [7:0]  b_req_wdata, b_rsp_rdata, b_bl, b_blb, b_sense_in;
  logic [15:0] b_wl;
  logic        b_precharge, b_bl_drive_en, b_sense_en;

  sram_ctrl u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wl(wl), .precharge(precharge),
    .bl_drive_en(bl_drive_en), .bl(bl), .blb(blb), .sense_en(sense_en), .sense_in(sense_in)
  );

  sram_ctrl #(.ADDR_W(4), .DATA_W(8), .PRE_CYC(3), .WL_CYC(1)) u_dut2 (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .wl(b_wl), .precharge(b_precharge),
    .bl_drive_en(b_bl_drive_en), .bl(b_bl), .blb(b_blb), .sense_en(b_sense_en), .sense_in(b_sense_in)
  );

  typedef struct packed {
    logic       rst;
    logic       vld;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] sense;
  } in_t;

  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic [7:0]  rdata;
    logic [15:0] wl;
    logic        pre;
    logic        drv;
    logic [7:0]  bl;
    logic [7:0]  blb;
    logic        sen;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  vec_t tbl[$];

  function automatic vec_t v(input logic rst, vld, we, input logic [3:0] a,
                             input logic [7:0] wd, sn,
                             input logic rdy, rv, input logic [7:0] rd,
                             input logic [15:0] w, input logic pre, drv,
                             input logic [7:0] b, bb, input logic sen);
    vec_t r;
    r.i = '{rst: rst, vld: vld, we: we, addr: a, wdata: wd, sense: sn};
    r.o = '{rdy: rdy, rv: rv, rdata: rd, wl: w, pre: pre, drv: drv, bl: b, blb: bb, sen: sen};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Break-before-make and one-hot wordline on every cycle, both instances.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(wl) || (precharge && |wl) || (bl_drive_en && sense_en) ||
          !$onehot0(b_wl) || (b_precharge && |b_wl) || (b_bl_drive_en && b_sense_en)) begin
        errors++;
        $display("FAIL invariant at %0t: wl=%h pre=%b drv=%b sen=%b | b_wl=%h b_pre=%b b_drv=%b b_sen=%b",
                 $time, wl, precharge, bl_drive_en, sense_en, b_wl, b_precharge, b_bl_drive_en, b_sense_en);
      end
    end
  end

  // Single read on the default instance; checks wordline, latency and read data.
  task automatic read_check(input logic [3:0] a, input logic [7:0] d);
    logic [15:0] exp_wl;
    int wl_n, lat;
    exp_wl = 16'd1 << a;
    wl_n = 0;
    lat = 0;
    chk("sweep ready before request", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'h00; sense_in = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (wl != 16'd0) begin
        wl_n++;
        chk("sweep wl address", 32'(wl), 32'(exp_wl));
      end
      if (rsp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("sweep latency", 32'(lat), 32'd4);
    chk("sweep wl cycles", 32'(wl_n), 32'd2);
    chk("sweep rdata", 32'(rsp_rdata), 32'(d));
    @(posedge clk); #1;
  endtask

  // Single access on the PRE_CYC=3, WL_CYC=1 instance with phase-length counting.
  task automatic b_access(input logic we, input logic [3:0] a, input logic [7:0] d);
    int pre_n, wl_n, drv_n, sen_n, lat;
    pre_n = 0; wl_n = 0; drv_n = 0; sen_n = 0; lat = 0;
    chk("p31 ready before request", 32'(b_req_ready), 32'd1);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = a; b_req_wdata = d; b_sense_in = d;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (b_precharge) pre_n++;
      if (b_wl != 16'd0) begin
        wl_n++;
        chk("p31 wl address", 32'(b_wl), 32'(16'd1 << a));
      end
      if (b_bl_drive_en) begin
        drv_n++;
        chk("p31 bl", 32'({b_bl, b_blb}), 32'({d, ~d}));
      end
      if (b_sense_en) sen_n++;
      if (b_rsp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("p31 latency", 32'(lat), 32'd5);
    chk("p31 precharge cycles", 32'(pre_n), 32'd3);
    chk("p31 wl cycles", 32'(wl_n), 32'd1);
    chk("p31 drive cycles", 32'(drv_n), we ? 32'd1 : 32'd0);
    chk("p31 sense cycles", 32'(sen_n), we ? 32'd0 : 32'd1);
    if (!we) chk("p31 rdata", 32'(b_rsp_rdata), 32'(d));
    @(posedge clk); #1;
    chk("p31 ready after response", 32'(b_req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t       act;
    logic [3:0] order [16];
    logic [3:0] tmp;
    int         j;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; sense_in = '0;
    b_reset = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_sense_in = '0;

    //                rst vld we addr wdata  sense   rdy rv rdata  wl       pre drv bl     blb    sen
    tbl.push_back(v(1, 0, 0, 4'd0, 8'h00, 8'h00,   1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0)); // reset
    tbl.push_back(v(0, 1, 1, 4'd3, 8'hA5, 8'h00,   0, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 8'h00, 0)); // write T -> T+1
    tbl.push_back(v(0, 0, 0, 4'd7, 8'hFF, 8'h00,   0, 0, 8'h00, 16'h0008, 0, 1, 8'hA5, 8'h5A, 0)); // fields changed: ignored
    tbl.push_back(v(0, 0, 0, 4'd7, 8'hFF, 8'h00,   0, 0, 8'h00, 16'h0008, 0, 1, 8'hA5, 8'h5A, 0));
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   0, 1, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0)); // write rsp, rdata unchanged
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(0, 1, 0, 4'd3, 8'h00, 8'h00,   0, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 8'h00, 0)); // read addr 3
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   0, 0, 8'h00, 16'h0008, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   0, 0, 8'h00, 16'h0008, 0, 0, 8'h00, 8'h00, 1)); // sense at T+3 only
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'hA5,   0, 1, 8'hA5, 16'h0000, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   1, 0, 8'hA5, 16'h0000, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 4'd0, 8'h3C, 8'h00,   0, 0, 8'hA5, 16'h0000, 1, 0, 8'h00, 8'h00, 0)); // write after read
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   0, 0, 8'hA5, 16'h0001, 0, 1, 8'h3C, 8'hC3, 0));
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   0, 0, 8'hA5, 16'h0001, 0, 1, 8'h3C, 8'hC3, 0));
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   0, 1, 8'hA5, 16'h0000, 0, 0, 8'h00, 8'h00, 0)); // rdata kept
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   1, 0, 8'hA5, 16'h0000, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(0, 1, 0, 4'd5, 8'h00, 8'h00,   0, 0, 8'hA5, 16'h0000, 1, 0, 8'h00, 8'h00, 0)); // back-to-back #1
    tbl.push_back(v(0, 1, 0, 4'd9, 8'h00, 8'h00,   0, 0, 8'hA5, 16'h0020, 0, 0, 8'h00, 8'h00, 0)); // busy: ignored
    tbl.push_back(v(0, 1, 0, 4'd9, 8'h00, 8'h00,   0, 0, 8'hA5, 16'h0020, 0, 0, 8'h00, 8'h00, 1));
    tbl.push_back(v(0, 1, 0, 4'd9, 8'h00, 8'h77,   0, 1, 8'h77, 16'h0000, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(0, 1, 0, 4'd9, 8'h00, 8'h00,   1, 0, 8'h77, 16'h0000, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(0, 1, 0, 4'd9, 8'h00, 8'h00,   0, 0, 8'h77, 16'h0000, 1, 0, 8'h00, 8'h00, 0)); // #2 at T+5
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   0, 0, 8'h77, 16'h0200, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   0, 0, 8'h77, 16'h0200, 0, 0, 8'h00, 8'h00, 1));
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h12,   0, 1, 8'h12, 16'h0000, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   1, 0, 8'h12, 16'h0000, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(0, 1, 1, 4'd2, 8'hF0, 8'h00,   0, 0, 8'h12, 16'h0000, 1, 0, 8'h00, 8'h00, 0)); // write, reset mid-way
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   0, 0, 8'h12, 16'h0004, 0, 1, 8'hF0, 8'h0F, 0));
    tbl.push_back(v(1, 0, 0, 4'd0, 8'h00, 8'h00,   1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0)); // reset at T+2
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0)); // no rsp ever
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(v(1, 1, 1, 4'd1, 8'h55, 8'h00,   1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0)); // reset + valid
    tbl.push_back(v(0, 0, 0, 4'd0, 8'h00, 8'h00,   1, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 8'h00, 0)); // not accepted

    for (int n = 0; n < tbl.size(); n++) begin
      reset     = tbl[n].i.rst;
      req_valid = tbl[n].i.vld;
      req_we    = tbl[n].i.we;
      req_addr  = tbl[n].i.addr;
      req_wdata = tbl[n].i.wdata;
      sense_in  = tbl[n].i.sense;
      @(posedge clk); #1;
      act = '{rdy: req_ready, rv: rsp_valid, rdata: rsp_rdata, wl: wl, pre: precharge,
              drv: bl_drive_en, bl: bl, blb: blb, sen: sense_en};
      checks++;
      if (act !== tbl[n].o) begin
        errors++;
        $display("FAIL row %0d: got rdy=%b rv=%b rdata=%h wl=%h pre=%b drv=%b bl=%h blb=%h sen=%b; expected rdy=%b rv=%b rdata=%h wl=%h pre=%b drv=%b bl=%h blb=%h sen=%b",
                 n, act.rdy, act.rv, act.rdata, act.wl, act.pre, act.drv, act.bl, act.blb, act.sen,
                 tbl[n].o.rdy, tbl[n].o.rv, tbl[n].o.rdata, tbl[n].o.wl, tbl[n].o.pre,
                 tbl[n].o.drv, tbl[n].o.bl, tbl[n].o.blb, tbl[n].o.sen);
      end
      if (n == 0) begin
        b_reset = 1'b0;
        mon_en  = 1'b1;
      end
    end
    reset = 1'b0; req_valid = 1'b0; sense_in = '0;

    // Read every address once, in shuffled order.
    for (int i = 0; i < 16; i++) order[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 16; i++) read_check(order[i], {order[i], ~order[i]});

    // Long precharge, single-cycle wordline instance.
    b_access(1'b1, 4'd6, 8'h81);
    b_access(1'b0, 4'd6, 8'h3E);
    b_access(1'b0, 4'd15, 8'hC7);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
